// File: rtl/memory_arbiter_if.sv
// Cache-side request/response and RAM-side bus of the shared memory arbiter.
// The arbiter takes the slave view; caches plus RAM together form the master view.
interface memory_arbiter_if;
   logic [1:0]  iREN;
   logic [1:0]  dREN;
   logic [1:0]  dWEN;
   logic [31:0] iaddr0;
   logic [31:0] iaddr1;
   logic [31:0] daddr0;
   logic [31:0] daddr1;
   logic [31:0] dstore0;
   logic [31:0] dstore1;
   logic [1:0]  iwait;
   logic [1:0]  dwait;
   logic [31:0] iload0;
   logic [31:0] iload1;
   logic [31:0] dload0;
   logic [31:0] dload1;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport slave (
      input  iREN, dREN, dWEN, iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1,
      input  ramload, ramstate,
      output iwait, dwait, iload0, iload1, dload0, dload1,
      output ramaddr, ramstore, ramREN, ramWEN
   );

   modport master (
      output iREN, dREN, dWEN, iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1,
      output ramload, ramstate,
      input  iwait, dwait, iload0, iload1, dload0, dload1,
      input  ramaddr, ramstore, ramREN, ramWEN
   );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates two cores' instruction and data requests onto one RAM port,
// data-first with round-robin per class and a starvation guard for instructions.
module memory_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic              CLK,
   input logic              nRST,
   memory_arbiter_if.slave  bus
);
   localparam int unsigned CW = 4;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   // source encoding: bit 1 = data class, bit 0 = core id
   localparam logic [1:0] SRC_I0 = 2'd0;
   localparam logic [1:0] SRC_I1 = 2'd1;
   localparam logic [1:0] SRC_D0 = 2'd2;
   localparam logic [1:0] SRC_D1 = 2'd3;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nx;
   logic [1:0]    gsrc, gsrc_nx;
   logic          gwr, gwr_nx;
   logic          iptr, iptr_nx;
   logic          dptr, dptr_nx;
   logic [CW-1:0] starve, starve_nx;

   logic [1:0] dreq;
   logic [3:0] req;
   logic       any_i, any_d;
   logic       i_core, d_core;
   logic       i_first, win_d;
   logic [1:0] win_src;
   logic       win_wr;
   logic       granted, access;

   // request vector indexed by source encoding
   always_comb begin
      dreq  = bus.dREN | bus.dWEN;
      req   = {dreq, bus.iREN};
      any_i = |bus.iREN;
      any_d = |dreq;
   end

   // winner selection: round-robin inside a class only on contention
   always_comb begin
      i_core  = (bus.iREN == 2'b11) ? iptr : bus.iREN[1];
      d_core  = (dreq == 2'b11) ? dptr : dreq[1];
      i_first = any_i && (starve == CW'(STARVE_LIMIT));
      win_d   = !i_first && any_d;
      win_src = {win_d, (win_d ? d_core : i_core)};
      win_wr  = win_d && bus.dWEN[d_core];
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         gsrc   <= SRC_I0;
         gwr    <= 1'b0;
         iptr   <= 1'b0;
         dptr   <= 1'b0;
         starve <= '0;
      end else begin
         state  <= state_nx;
         gsrc   <= gsrc_nx;
         gwr    <= gwr_nx;
         iptr   <= iptr_nx;
         dptr   <= dptr_nx;
         starve <= starve_nx;
      end
   end

   // next state, grant latch, pointer and starvation bookkeeping
   always_comb begin
      state_nx  = state;
      gsrc_nx   = gsrc;
      gwr_nx    = gwr;
      iptr_nx   = iptr;
      dptr_nx   = dptr;
      starve_nx = any_i ? starve : '0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_nx = GRANT;
               gsrc_nx  = win_src;
               gwr_nx   = win_wr;
            end
         end
         GRANT: begin
            if (bus.ramstate == RAM_ACCESS) begin
               state_nx = IDLE;
               if (gsrc[1]) begin
                  dptr_nx = ~gsrc[0];
                  if (any_i && (starve < CW'(STARVE_LIMIT))) begin
                     starve_nx = starve + CW'(1);
                  end
               end else begin
                  iptr_nx   = ~gsrc[0];
                  starve_nx = '0;
               end
            end else if ((bus.ramstate == RAM_ERROR) || !req[gsrc]) begin
               // error retries via re-arbitration; a dropped request is an abort
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign granted = (state == GRANT);
   assign access  = granted && (bus.ramstate == RAM_ACCESS);

   // RAM strobes from the latched grant; load and wait release to the winner
   always_comb begin
      bus.iwait    = 2'b11;
      bus.dwait    = 2'b11;
      bus.iload0   = '0;
      bus.iload1   = '0;
      bus.dload0   = '0;
      bus.dload1   = '0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      if (granted) begin
         bus.ramREN = !gwr;
         bus.ramWEN = gwr;
         unique case (gsrc)
            SRC_I0: begin
               bus.ramaddr  = bus.iaddr0;
               bus.iload0   = bus.ramload;
               bus.iwait[0] = !access;
            end
            SRC_I1: begin
               bus.ramaddr  = bus.iaddr1;
               bus.iload1   = bus.ramload;
               bus.iwait[1] = !access;
            end
            SRC_D0: begin
               bus.ramaddr  = bus.daddr0;
               bus.ramstore = bus.dstore0;
               bus.dload0   = bus.ramload;
               bus.dwait[0] = !access;
            end
            SRC_D1: begin
               bus.ramaddr  = bus.daddr1;
               bus.ramstore = bus.dstore1;
               bus.dload1   = bus.ramload;
               bus.dwait[1] = !access;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: single-transaction vector table plus
// hand-written arbitration, starvation, retry, abort and reset sequences.
module tb_memory_arbiter;
   localparam int unsigned SL = 2;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
   localparam logic [1:0] I0 = 2'd0, I1 = 2'd1, D0 = 2'd2, D1 = 2'd3;

   logic CLK = 1'b0;
   logic nRST;

   memory_arbiter_if bus ();

   memory_arbiter #(.STARVE_LIMIT(SL)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  src;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] rdata;
      logic [3:0]  nbusy;
      logic        exp_ren;
      logic        exp_wen;
   } vec_t;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] load;
   } exp_t;

   localparam int NV = 7;
   vec_t vt [NV];
   vec_t v;
   exp_t sbq [$];
   exp_t mon_e;
   logic [3:0] mon_low;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] addr_of(input logic [1:0] s);
      case (s)
         I0:      return 32'h0000_1000;
         I1:      return 32'h0000_1100;
         D0:      return 32'h0000_2000;
         default: return 32'h0000_2100;
      endcase
   endfunction

   function automatic logic [31:0] load_of(input logic [1:0] s);
      case (s)
         I0:      return bus.iload0;
         I1:      return bus.iload1;
         D0:      return bus.dload0;
         default: return bus.dload1;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] s, input logic [31:0] d);
      exp_t e;
      e.src  = s;
      e.load = d;
      sbq.push_back(e);
   endtask

   task automatic set_default_addrs();
      bus.iaddr0  = addr_of(I0);
      bus.iaddr1  = addr_of(I1);
      bus.daddr0  = addr_of(D0);
      bus.daddr1  = addr_of(D1);
      bus.dstore0 = 32'h5000_0000;
      bus.dstore1 = 32'h5100_0000;
   endtask

   task automatic set_src(input logic [1:0] s, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] store);
      case (s)
         I0: begin bus.iaddr0 = addr; bus.iREN[0] = ren; end
         I1: begin bus.iaddr1 = addr; bus.iREN[1] = ren; end
         D0: begin bus.daddr0 = addr; bus.dstore0 = store; bus.dREN[0] = ren; bus.dWEN[0] = wen; end
         default: begin bus.daddr1 = addr; bus.dstore1 = store; bus.dREN[1] = ren; bus.dWEN[1] = wen; end
      endcase
   endtask

   task automatic clear_reqs();
      bus.iREN = 2'b00;
      bus.dREN = 2'b00;
      bus.dWEN = 2'b00;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_waits"}, 32'({bus.dwait, bus.iwait}), 32'hF);
      chk({tag, "_iload0"}, bus.iload0, 32'h0);
      chk({tag, "_iload1"}, bus.iload1, 32'h0);
      chk({tag, "_dload0"}, bus.dload0, 32'h0);
      chk({tag, "_dload1"}, bus.dload1, 32'h0);
      chk({tag, "_strobes"}, 32'({bus.ramREN, bus.ramWEN}), 32'h0);
      chk({tag, "_ramaddr"}, bus.ramaddr, 32'h0);
      chk({tag, "_ramstore"}, bus.ramstore, 32'h0);
   endtask

   task automatic do_reset();
      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      sbq.delete();
      nRST = 1'b0;
      clear_reqs();
      set_default_addrs();
      bus.ramstate = FREE;
      bus.ramload  = 32'h0;
      @(negedge CLK);
      check_idle_outputs("reset");
      tick();
      nRST = 1'b1;
   endtask

   // Precondition: IDLE cycle with the competing requests already driven.
   task automatic grant_access(input logic [1:0] s, input logic [31:0] d);
      tick();
      bus.ramstate = ACCESS;
      bus.ramload  = d;
      push_exp(s, d);
      @(negedge CLK);
      chk("grant_addr", bus.ramaddr, addr_of(s));
      chk("grant_strobe", 32'(bus.ramREN | bus.ramWEN), 32'h1);
      tick();
      bus.ramstate = FREE;
      @(negedge CLK);
      chk("post_access_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
   endtask

   // Every wait pulse must match the next expected completion.
   always @(negedge CLK) begin
      if (nRST === 1'b1) begin
         mon_low = {~bus.dwait, ~bus.iwait};
         if (mon_low != 4'h0) begin
            if (sbq.size() == 0) begin
               chk("unexpected_wait_pulse", 32'(mon_low), 32'h0);
            end else begin
               mon_e = sbq.pop_front();
               chk("wait_src", 32'(mon_low), 32'(4'b0001 << mon_e.src));
               for (int s = 0; s < 4; s++) begin
                  chk($sformatf("load_src%0d", s), load_of(2'(s)),
                      (2'(s) == mon_e.src) ? mon_e.load : 32'h0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{D0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 4'd2, 1'b1, 1'b0};
      vt[1] = '{D1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 4'd0, 1'b1, 1'b0};
      vt[2] = '{I0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0013, 4'd1, 1'b1, 1'b0};
      vt[3] = '{I1, 1'b1, 1'b0, 32'h0000_2004, 32'h0, 32'h0000_0093, 4'd0, 1'b1, 1'b0};
      vt[4] = '{D1, 1'b0, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0, 4'd0, 1'b0, 1'b1};
      vt[5] = '{D0, 1'b0, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 32'h0, 4'd3, 1'b0, 1'b1};
      vt[6] = '{D0, 1'b1, 1'b1, 32'h0000_0208, 32'h5A5A_0000, 32'h0, 4'd0, 1'b0, 1'b1};

      nRST = 1'b0;
      do_reset();

      // single transactions from the vector table
      for (int k = 0; k < NV; k++) begin
         v = vt[k];
         set_src(v.src, v.ren, v.wen, v.addr, v.store);
         @(negedge CLK);
         chk("no_strobe_same_cycle", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
         tick();
         for (int b = 0; b <= int'(v.nbusy); b++) begin
            bus.ramstate = (b == int'(v.nbusy)) ? ACCESS : BUSY;
            bus.ramload  = (b == int'(v.nbusy)) ? v.rdata : 32'hFFFF_FFFF;
            if (b == int'(v.nbusy)) push_exp(v.src, v.rdata);
            @(negedge CLK);
            chk($sformatf("vec%0d_ramREN", k), 32'(bus.ramREN), 32'(v.exp_ren));
            chk($sformatf("vec%0d_ramWEN", k), 32'(bus.ramWEN), 32'(v.exp_wen));
            chk($sformatf("vec%0d_ramaddr", k), bus.ramaddr, v.addr);
            if (v.wen) chk($sformatf("vec%0d_ramstore", k), bus.ramstore, v.store);
            if (b < int'(v.nbusy)) chk($sformatf("vec%0d_busy_waits", k),
                                      32'({bus.dwait, bus.iwait}), 32'hF);
            tick();
         end
         clear_reqs();
         bus.ramstate = FREE;
         @(negedge CLK);
         check_idle_outputs($sformatf("vec%0d_after", k));
         tick();
      end

      // D0 and D1 both held: strict alternation, 2 cycles per grant
      do_reset();
      bus.dREN = 2'b11;
      grant_access(D0, 32'h0000_0A00);
      grant_access(D1, 32'h0000_0A01);
      grant_access(D0, 32'h0000_0A02);
      grant_access(D1, 32'h0000_0A03);
      clear_reqs();
      tick();

      // I0 pending against a persistent D1: I0 gets in after SL data grants
      do_reset();
      bus.iREN = 2'b01;
      bus.dREN = 2'b10;
      grant_access(D1, 32'h0000_0B00);
      grant_access(D1, 32'h0000_0B01);
      grant_access(I0, 32'h0000_0B02);
      grant_access(D1, 32'h0000_0B03);
      grant_access(D1, 32'h0000_0B04);
      grant_access(I0, 32'h0000_0B05);
      clear_reqs();
      tick();

      // D0 write: ERROR then ACCESS, single wait pulse, dptr flips once
      do_reset();
      bus.daddr0  = 32'h0000_0200;
      bus.dstore0 = 32'h1234_5678;
      bus.dWEN    = 2'b01;
      tick();
      bus.ramstate = ERROR;
      @(negedge CLK);
      chk("err_ramWEN", 32'(bus.ramWEN), 32'h1);
      chk("err_ramaddr", bus.ramaddr, 32'h0000_0200);
      chk("err_no_wait", 32'({bus.dwait, bus.iwait}), 32'hF);
      tick();
      bus.ramstate = FREE;
      @(negedge CLK);
      chk("err_idle_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
      tick();
      bus.ramstate = ACCESS;
      bus.ramload  = 32'h0;
      push_exp(D0, 32'h0);
      @(negedge CLK);
      chk("retry_ramWEN", 32'(bus.ramWEN), 32'h1);
      chk("retry_ramaddr", bus.ramaddr, 32'h0000_0200);
      chk("retry_ramstore", bus.ramstore, 32'h1234_5678);
      tick();
      bus.ramstate = FREE;
      clear_reqs();
      set_default_addrs();
      bus.dREN = 2'b11;
      grant_access(D1, 32'h0000_0C00);
      clear_reqs();
      tick();

      // D1 aborts while BUSY; pending I1 is served next; dptr untouched
      do_reset();
      bus.dREN = 2'b10;
      bus.iREN = 2'b10;
      tick();
      bus.ramstate = BUSY;
      @(negedge CLK);
      chk("abort_granted_addr", bus.ramaddr, addr_of(D1));
      chk("abort_granted_ren", 32'(bus.ramREN), 32'h1);
      tick();
      bus.dREN = 2'b00;
      @(negedge CLK);
      chk("abort_no_wait", 32'({bus.dwait, bus.iwait}), 32'hF);
      tick();
      bus.ramstate = FREE;
      @(negedge CLK);
      chk("abort_idle_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
      grant_access(I1, 32'h0000_0D00);
      bus.iREN = 2'b00;
      bus.dREN = 2'b11;
      grant_access(D0, 32'h0000_0D01);
      clear_reqs();
      tick();

      // reset in the middle of a D1 grant, then pointers restart at 0
      do_reset();
      bus.dREN = 2'b01;
      grant_access(D0, 32'h0000_0E00);
      bus.dREN = 2'b11;
      tick();
      bus.ramstate = BUSY;
      @(negedge CLK);
      chk("pre_reset_winner", bus.ramaddr, addr_of(D1));
      #2;
      nRST = 1'b0;
      #1;
      chk("async_reset_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
      chk("async_reset_waits", 32'({bus.dwait, bus.iwait}), 32'hF);
      chk("async_reset_ramaddr", bus.ramaddr, 32'h0);
      tick();
      tick();
      bus.ramstate = FREE;
      nRST = 1'b1;
      grant_access(D0, 32'h0000_0E01);
      clear_reqs();
      tick();
      tick();

      chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the instruction and data RAM requests of two cores' caches onto the single shared RAM port. Grants one transaction at a time, holds it until RAM reports ACCESS, and returns load data and a one-cycle wait release to the winning requester. Sits between the two cache blocks and the RAM-facing signals of the multicore top.

## Interface
- `STARVE_LIMIT`, 8: consecutive completed data grants allowed while any instruction request is pending. Range 1..15.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `iREN[1:0]` in 2: instruction read request, index = core ID.
- `iaddr0`, `iaddr1` in 32 each: instruction addresses.
- `dREN[1:0]`, `dWEN[1:0]` in 2 each: data read/write requests. Both set for one core is illegal.
- `daddr0`, `daddr1`, `dstore0`, `dstore1` in 32 each: data address and write data.
- `iwait[1:0]`, `dwait[1:0]` out 2 each: low for exactly one cycle when the granted transaction completes. High otherwise.
- `iload0`, `iload1`, `dload0`, `dload1` out 32 each: `ramload` forwarded to the granted source. 0 for all other sources.
- `ramaddr`, `ramstore` out 32 each: RAM address and write data.
- `ramREN`, `ramWEN` out 1 each: RAM strobes.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- Sources: I0, I1, D0, D1. A source is requesting while its REN/WEN is high.
- FSM states:
  - IDLE: no grant. RAM strobes 0, `ramaddr`/`ramstore` 0.
  - GRANT: the registered grant drives `ramaddr`, `ramstore`, and `ramREN` or `ramWEN` from the granted source.
- IDLE → GRANT: on the first edge with any request. The winner is latched.
- Winner selection:
  - If the starve counter equals `STARVE_LIMIT` and any I request is pending, the instruction class wins.
  - Otherwise the data class wins if any D request is pending, else the instruction class.
- Within a class, round-robin: a per-class pointer (`dptr`, `iptr`, reset 0) names the preferred core. If only one core requests, it wins regardless of the pointer.
- In GRANT:
  - If `ramstate==ACCESS`: the granted wait is low this cycle and its load output = `ramload`. Next state is IDLE. The class pointer flips to the other core.
  - If `ramstate==ERROR`: next state IDLE. No wait release, no pointer update. The request is re-arbitrated, which is a retry.
  - If the granted request drops before ACCESS (abort): next state IDLE. No wait release, no pointer or counter update.
  - FREE/BUSY: hold the grant.
- Starve counter (4 bits, reset 0):
  - +1 on each completed D grant while any I request is pending.
  - Cleared on any completed I grant, or when no I request is pending.
  - Saturates at `STARVE_LIMIT`.
- Write data is taken from `dstoreN` combinationally while granted. The requester must hold address and data stable until its wait drops.

## Timing
- Reset values: FSM IDLE, pointers 0, counter 0, all waits 1, all loads 0, `ramREN`/`ramWEN` 0, `ramaddr`/`ramstore` 0.
- Arbitration latency: a request raised in cycle t drives the RAM strobes in cycle t+1 at the earliest.
- Completion: wait is low combinationally in the cycle `ramstate==ACCESS`. The RAM strobes drop the next cycle (IDLE).
- Back-to-back: minimum 2 cycles per transaction (IDLE, then GRANT with immediate ACCESS). A source that keeps requesting after completion re-arbitrates in the IDLE cycle and competes normally.
- Simultaneous events:
  - Request arrival in IDLE at the same edge as another source completes: that arrival is included in the next arbitration.
  - ACCESS and request drop in the same cycle: treated as completion.
- Reset mid-GRANT: immediate return to reset values. No wait pulse.
- Illegal dREN&dWEN on one core: the write takes precedence (`ramWEN` only).

## Test plan
- Single D0 read at 0x40, RAM returns 0xDEADBEEF after 2 BUSY cycles:
  - `ramREN`=1 with `ramaddr`=0x40 from cycle t+1.
  - `dwait[0]` low for 1 cycle exactly when ACCESS arrives, with `dload0`=0xDEADBEEF.
  - `dload1`, `iload0`, `iload1` = 0.
- D0 and D1 held requesting continuously, ACCESS after 1 cycle each:
  - Grants alternate D0, D1, D0, D1.
  - Each wait pulse is 1 cycle; 2-cycle period per grant.
- I0 and D1 requesting, `STARVE_LIMIT`=2, D1 kept re-requesting:
  - Order is D1, D1, I0, then the counter clears.
  - D1 never starves I0 beyond 2 completions.
- D0 write 0x12345678 to 0x200, ERROR on the first attempt, ACCESS on the second:
  - Two separate GRANT periods.
  - `dwait[0]` pulses once, only after the ACCESS.
  - `dptr` flips once.
- D1 granted while BUSY, `dREN[1]` drops before ACCESS:
  - Returns to IDLE, no wait pulse, `dptr` unchanged.
  - A pending I1 is granted next cycle.
- `nRST` asserted mid-GRANT:
  - `ramREN`/`ramWEN` go 0 and all waits go 1 asynchronously.
  - After release, the first arbitration uses pointers = 0.
